// File: rtl/tremolo_mc.sv
// Multi-channel fixed-point tremolo with its own phase-accumulator LFO and one shared multiplier.
// Define TREMOLO_STEREO_SPREAD_EN to give each channel its own LFO phase offset (phase + c*2^PHASE_WIDTH/CHANNELS).
module tremolo_mc #(
  parameter int DATA_WIDTH  = 16,
  parameter int CHANNELS    = 2,
  parameter int PHASE_WIDTH = 24
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           alpha_control_key,
  input  logic                           modfreq_control_key,
  input  logic                           wave_control_key,
  input  logic                           cs,
  input  logic                           my_turn,
  input  logic [CHANNELS*DATA_WIDTH-1:0] data_in,
  output logic                           done,
  output logic                           busy,
  output logic [CHANNELS*DATA_WIDTH-1:0] data_out
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LFO  = 2'd1;
  localparam logic [1:0] S_MUL  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int XW = DATA_WIDTH + 17;
  localparam logic signed [XW-1:0] Y_MAX = $signed({{(XW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}});
  localparam logic signed [XW-1:0] Y_MIN = $signed({{(XW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}});

  // Rounded phase increment for f Hz at a 48 kHz sample rate.
  function automatic logic [PHASE_WIDTH-1:0] rate_incr(input int unsigned f);
    logic [63:0] num;
    num = ({32'd0, f} << PHASE_WIDTH) + 64'd24000;
    return PHASE_WIDTH'(num / 64'd48000);
  endfunction

  localparam logic [15:0] ALPHA_LUT [8] = '{16'd0, 16'd6554, 16'd11469, 16'd16384,
                                            16'd21299, 16'd24576, 16'd27853, 16'd32767};
  localparam logic [PHASE_WIDTH-1:0] RATE_LUT [8] = '{rate_incr(32'd5), rate_incr(32'd7),
      rate_incr(32'd9), rate_incr(32'd11), rate_incr(32'd13), rate_incr(32'd15),
      rate_incr(32'd17), rate_incr(32'd20)};

  logic [1:0]                     state_r;
  logic [CW-1:0]                  ch_r;
  logic [PHASE_WIDTH-1:0]         phase_r;
  logic [PHASE_WIDTH-1:0]         incr_cur_r;
  logic [2:0]                     alpha_opt_r;
  logic [2:0]                     rate_opt_r;
  logic [1:0]                     wave_opt_r;
  logic [15:0]                    alpha_cur_r;
  logic [1:0]                     wave_cur_r;
  logic [CHANNELS*DATA_WIDTH-1:0] x_r;
  logic [CHANNELS*DATA_WIDTH-1:0] stage_r;
  logic [CHANNELS*DATA_WIDTH-1:0] data_out_r;
  logic signed [15:0]             m_r;
  logic                           done_r;
  logic                           busy_r;

  logic [PHASE_WIDTH-1:0]         ch_phase_s;
  logic [15:0]                    u_s;
  logic signed [18:0]             w_wide_s;
  logic signed [15:0]             w_s;
  logic signed [32:0]             am_s;
  logic signed [15:0]             m_next_s;
  logic signed [DATA_WIDTH-1:0]   x_s;
  logic signed [XW-1:0]           xm_s;
  logic signed [XW-1:0]           sum_s;
  logic [DATA_WIDTH-1:0]          y_s;

`ifdef TREMOLO_STEREO_SPREAD_EN
  localparam logic [PHASE_WIDTH-1:0] SPREAD_STEP = PHASE_WIDTH'((64'd1 << PHASE_WIDTH) / 64'(CHANNELS));
  assign ch_phase_s = phase_r + PHASE_WIDTH'(ch_r) * SPREAD_STEP;
`else
  assign ch_phase_s = phase_r;
`endif
  assign u_s = 16'(ch_phase_s >> (PHASE_WIDTH - 16));

  // LFO waveform generation from the top 16 phase bits.
  always_comb begin
    w_wide_s = 19'sd0;
    case (wave_cur_r)
      2'd0: begin
        if (u_s[15] == 1'b0) begin
          w_wide_s = $signed({2'b00, u_s, 1'b0}) - 19'sd32768;
        end else begin
          w_wide_s = 19'sd98303 - $signed({2'b00, u_s, 1'b0});
        end
      end
      2'd1: begin
        if (u_s[15] == 1'b0) begin
          w_wide_s = 19'sd32767;
        end else begin
          w_wide_s = -19'sd32768;
        end
      end
      2'd2:    w_wide_s = $signed({3'b000, u_s}) - 19'sd32768;
      default: w_wide_s = 19'sd0;
    endcase
  end

  assign w_s      = 16'(w_wide_s);
  assign am_s     = $signed({17'd0, alpha_cur_r}) * $signed({{17{w_s[15]}}, w_s});
  assign m_next_s = 16'(am_s >>> 15);
  assign x_s      = x_r[ch_r*DATA_WIDTH +: DATA_WIDTH];
  assign xm_s     = $signed({{17{x_s[DATA_WIDTH-1]}}, x_s}) * $signed({{(DATA_WIDTH+1){m_r[15]}}, m_r});
  assign sum_s    = (xm_s >>> 15) + $signed({{17{x_s[DATA_WIDTH-1]}}, x_s});

  // Saturate the modulated sample to the signed sample range.
  always_comb begin
    if (sum_s > Y_MAX) begin
      y_s = DATA_WIDTH'(Y_MAX);
    end else if (sum_s < Y_MIN) begin
      y_s = DATA_WIDTH'(Y_MIN);
    end else begin
      y_s = DATA_WIDTH'(sum_s);
    end
  end

  // Option keys are live in every state; accept snapshots them.
  always_ff @(posedge clk) begin
    if (rst) begin
      alpha_opt_r <= 3'd0;
      rate_opt_r  <= 3'd0;
      wave_opt_r  <= 2'd0;
    end else begin
      if (alpha_control_key)   alpha_opt_r <= alpha_opt_r + 3'd1;
      if (modfreq_control_key) rate_opt_r  <= rate_opt_r + 3'd1;
      if (wave_control_key)    wave_opt_r  <= (wave_opt_r >= 2'd2) ? 2'd0 : wave_opt_r + 2'd1;
    end
  end

  // Sample sequencer: accept, per-channel LFO/multiply, then publish and advance phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_IDLE;
      ch_r        <= '0;
      phase_r     <= '0;
      incr_cur_r  <= '0;
      alpha_cur_r <= 16'd0;
      wave_cur_r  <= 2'd0;
      x_r         <= '0;
      stage_r     <= '0;
      data_out_r  <= '0;
      m_r         <= 16'sd0;
      done_r      <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (cs && my_turn && !busy_r) begin
            x_r         <= data_in;
            alpha_cur_r <= ALPHA_LUT[alpha_opt_r];
            wave_cur_r  <= wave_opt_r;
            incr_cur_r  <= RATE_LUT[rate_opt_r];
            ch_r        <= '0;
            busy_r      <= 1'b1;
            state_r     <= S_LFO;
          end else if (done_r) begin
            busy_r <= 1'b0;
          end
        end
        S_LFO: begin
          m_r     <= m_next_s;
          state_r <= S_MUL;
        end
        S_MUL: begin
          stage_r[ch_r*DATA_WIDTH +: DATA_WIDTH] <= y_s;
          if (ch_r == CW'(CHANNELS - 1)) begin
            state_r <= S_DONE;
          end else begin
            ch_r <= ch_r + CW'(1);
`ifdef TREMOLO_STEREO_SPREAD_EN
            state_r <= S_LFO;
`else
            state_r <= S_MUL;
`endif
          end
        end
        S_DONE: begin
          data_out_r <= stage_r;
          done_r     <= 1'b1;
          phase_r    <= phase_r + incr_cur_r;
          state_r    <= S_IDLE;
        end
        default: state_r <= S_IDLE;
      endcase
    end
  end

  assign done     = done_r;
  assign busy     = busy_r;
  assign data_out = data_out_r;

endmodule

// File: tb/tb_tremolo_mc.sv
// Testbench for tremolo_mc: table-driven vectors plus a model-fed scoreboard for long runs and corner cases.
module tb_tremolo_mc;
  localparam int DW = 16;
  localparam int CH = 2;
  localparam int PW = 24;
`ifdef TREMOLO_STEREO_SPREAD_EN
  localparam int DONE_CYC = 2*CH + 1;
  localparam int SPREAD   = 1;
`else
  localparam int DONE_CYC = CH + 2;
  localparam int SPREAD   = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic alpha_control_key = 1'b0;
  logic modfreq_control_key = 1'b0;
  logic wave_control_key = 1'b0;
  logic cs = 1'b0;
  logic my_turn = 1'b0;
  logic [CH*DW-1:0] data_in = '0;
  logic done;
  logic busy;
  logic [CH*DW-1:0] data_out;

  tremolo_mc #(.DATA_WIDTH(DW), .CHANNELS(CH), .PHASE_WIDTH(PW)) dut (
    .clk(clk), .rst(rst),
    .alpha_control_key(alpha_control_key), .modfreq_control_key(modfreq_control_key),
    .wave_control_key(wave_control_key), .cs(cs), .my_turn(my_turn),
    .data_in(data_in), .done(done), .busy(busy), .data_out(data_out)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int alpha_tab [8] = '{0, 6554, 11469, 16384, 21299, 24576, 27853, 32767};
  int incr_tab  [8] = '{1748, 2447, 3146, 3845, 4544, 5243, 5942, 6991};
  int m_alpha, m_rate, m_wave;
  logic [PW-1:0] m_phase;

  typedef struct { int e0; int e1; } exp_t;
  typedef struct { int alpha_n; int wave_n; int x0; int x1; int e0; int e1; } vec_t;
  exp_t sb_q [$];
  vec_t vecs [5];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int model_w(input int wave, input logic [PW-1:0] ph);
    int u;
    u = int'(ph[PW-1 -: 16]);
    case (wave)
      0:       return (u < 32768) ? 2*u - 32768 : 98303 - 2*u;
      1:       return (u < 32768) ? 32767 : -32768;
      default: return u - 32768;
    endcase
  endfunction

  function automatic int model_y(input int x, input int alpha, input int w);
    int m;
    longint p, y;
    m = (alpha * w) >>> 15;
    p = longint'(x) * longint'(m);
    y = longint'(x) + (p >>> 15);
    if (y > 32767) return 32767;
    if (y < -32768) return -32768;
    return int'(y);
  endfunction

  function automatic int model_ch(input int c, input int x);
    logic [PW-1:0] p;
    p = m_phase;
    if (SPREAD != 0) p = m_phase + PW'(c * ((1 << PW) / CH));
    return model_y(x, alpha_tab[m_alpha], model_w(m_wave, p));
  endfunction

  function automatic int s16(input logic [15:0] v);
    return int'($signed(v));
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    m_alpha = 0; m_rate = 0; m_wave = 0; m_phase = '0;
    sb_q.delete();
  endtask

  task automatic press(input int which, input int n);
    for (int i = 0; i < n; i++) begin
      alpha_control_key   = (which == 0);
      modfreq_control_key = (which == 1);
      wave_control_key    = (which == 2);
      tick;
      alpha_control_key = 1'b0; modfreq_control_key = 1'b0; wave_control_key = 1'b0;
      if (which == 0) m_alpha = (m_alpha + 1) % 8;
      else if (which == 1) m_rate = (m_rate + 1) % 8;
      else m_wave = (m_wave + 1) % 3;
    end
  endtask

  task automatic run_sample(input int x0, input int x1, input bit use_model, input int e0, input int e1,
                            input bit glitch, input bit key_mid, input bit timing);
    exp_t e, got;
    int cyc, rate_acc;
    bit seen;
    logic [CH*DW-1:0] prev;
    cyc = 0;
    while (busy && cyc < 50) begin tick; cyc++; end
    if (busy) check("idle_wait", busy, 0);
    data_in = {x1[15:0], x0[15:0]};
    cs = 1'b1; my_turn = 1'b1;
    if (use_model) begin e.e0 = model_ch(0, x0); e.e1 = model_ch(1, x1); end
    else begin e.e0 = e0; e.e1 = e1; end
    sb_q.push_back(e);
    rate_acc = incr_tab[m_rate];
    prev = data_out;
    tick;
    cs = 1'b0; my_turn = 1'b0;
    data_in = (CH*DW)'($urandom);
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 40) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        if (timing) begin
          check("busy_during", busy, 1);
          check("data_out_hold", data_out, prev);
        end
        cs = glitch && (cyc == 1);
        my_turn = glitch && (cyc == 1);
        wave_control_key = key_mid && (cyc == 1);
        if (key_mid && cyc == 1) m_wave = (m_wave + 1) % 3;
        tick;
        cs = 1'b0; my_turn = 1'b0; wave_control_key = 1'b0;
        cyc++;
      end
    end
    if (!seen) begin
      check("done_timeout", done, 1);
    end else begin
      if (timing) begin
        check("done_cycle", cyc, DONE_CYC);
        check("busy_at_done", busy, 1);
      end
      got = sb_q.pop_front();
      check("ch0", s16(data_out[15:0]), got.e0);
      check("ch1", s16(data_out[31:16]), got.e1);
      m_phase = m_phase + PW'(rate_acc);
      tick;
      check("done_one_cycle", done, 0);
      check("busy_cleared", busy, 0);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{0, 0, 1000, -2000, 1000, -2000};
`ifdef TREMOLO_STEREO_SPREAD_EN
    vecs[1] = '{7, 1, 20000, -20000, 32767, -1};
    vecs[2] = '{3, 0, 1000, -3000, 500, -4500};
    vecs[3] = '{7, 2, 1000, -1000, 0, -1000};
    vecs[4] = '{7, 1, 1000, 1000, 1999, 0};
`else
    vecs[1] = '{7, 1, 20000, -20000, 32767, -32768};
    vecs[2] = '{3, 0, 1000, -3000, 500, -1500};
    vecs[3] = '{7, 2, 1000, -1000, 0, -1};
    vecs[4] = '{7, 1, 1000, 1000, 1999, 1999};
`endif

    do_reset;
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_data_out", data_out, 0);

    for (int i = 0; i < 5; i++) begin
      do_reset;
      press(0, vecs[i].alpha_n);
      press(2, vecs[i].wave_n);
      run_sample(vecs[i].x0, vecs[i].x1, 1'b0, vecs[i].e0, vecs[i].e1, 1'b0, 1'b0, 1'b1);
    end

    // Long run at the fastest rate to exercise the phase wrap.
    do_reset;
    press(1, 7);
    press(0, 7);
    press(2, 2);
    for (int i = 0; i < 2400; i++) begin
      run_sample(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768,
                 1'b1, 0, 0, (i == 5), (i == 10), (i < 12));
    end
    check("phase_after_2400", dut.phase_r, 1184);

    // Reset in the middle of a sample.
    do_reset;
    press(0, 3);
    run_sample(1000, 1000, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0);
    data_in = {16'd3000, 16'd3000};
    cs = 1'b1; my_turn = 1'b1;
    tick;
    cs = 1'b0; my_turn = 1'b0;
    tick;
    check("in_mul_before_rst", dut.state_r, 2);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("rst_mid_state", dut.state_r, 0);
    check("rst_mid_done", done, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_data_out", data_out, 0);
    check("rst_mid_alpha_opt", dut.alpha_opt_r, 0);
    for (int i = 0; i < 8; i++) begin
      check("no_done_after_rst", done, 0);
      tick;
    end
    m_alpha = 0; m_rate = 0; m_wave = 0; m_phase = '0;
    run_sample(-1234, 4321, 1'b0, -1234, 4321, 1'b0, 1'b0, 1'b1);
    press(0, 5);
    press(2, 1);
    run_sample(-25000, 30000, 1'b1, 0, 0, 1'b0, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tremolo_mc.md
# tremolo_mc

Multi-channel fixed-point tremolo: the parametrised successor to the single-channel floating-point tremolo in the audio effects chain. It has its own phase-accumulator LFO with selectable waveform, so it needs neither the shared FP unit nor the sinus unit. Per accepted sample it amplitude-modulates `CHANNELS` samples with one shared multiplier and reports completion through the effects-chain `cs`/`my_turn`/`done` handshake.

## Interface
- `DATA_WIDTH`, 16: signed sample width per channel.
- `CHANNELS`, 2: channel count (≥1); channels are packed, ch0 in the LSBs.
- `PHASE_WIDTH`, 24: LFO phase accumulator width (≥16).
- `clk` in 1: the only clock.
- `rst` in 1: synchronous, active-high reset.
- `alpha_control_key` in 1: one-cycle pulse; steps the depth option.
- `modfreq_control_key` in 1: one-cycle pulse; steps the rate option.
- `wave_control_key` in 1: one-cycle pulse; steps the waveform.
- `cs` in 1: effect selected.
- `my_turn` in 1: chain grants this effect the current sample.
- `data_in` in CHANNELS*DATA_WIDTH: input samples.
- `done` out 1: one-cycle completion pulse.
- `busy` out 1: high from accept until `done` inclusive.
- `data_out` out CHANNELS*DATA_WIDTH: processed samples, registered.

## Operation
- Reset: state IDLE, `done`=0, `busy`=0, `data_out`=0, phase=0, alpha_option=0, modfreq_option=0, wave=0.
- Keys are sampled in every state. Each asserted cycle increments its option. Alpha and rate wrap 7→0; wave wraps 2→0. Options are captured at accept and hold constant for that sample.
- Depth table α (unsigned Q0.15): 0, 6554, 11469, 16384, 21299, 24576, 27853, 32767.
- Rate table: incr = round(f·2^PHASE_WIDTH/48000), with f ∈ {5,7,9,11,13,15,17,20} Hz, computed at elaboration.
- FSM:
  - IDLE: on `cs && my_turn`, latch `data_in` and the options, set ch=0, go to LFO.
  - LFO: compute w for ch, go to MUL.
  - MUL: compute y for ch into staging. If ch<CHANNELS-1, increment ch and return to LFO (spread) or stay in MUL (no spread). Otherwise go to DONE.
  - DONE: copy staging to `data_out`, pulse `done`, phase += incr (mod 2^PHASE_WIDTH), go to IDLE.
- Waveform from u = top 16 bits of the channel phase; w is signed 16-bit:
  - triangle (0): u[15]=0 gives 2u−32768; u[15]=1 gives 98303−2u.
  - square (1): u[15]=0 gives 32767; u[15]=1 gives −32768.
  - ramp (2): u−32768.
- Modifier: m = (α·w) >>> 15, arithmetic shift (floor), signed 16-bit.
- Output: y = x + ((x·m) >>> 15), computed at DATA_WIDTH+17 bits, then saturated to the signed DATA_WIDTH range.
- `cs`/`my_turn` are ignored while busy. `data_in` changes after accept are ignored.
- `rst` mid-sample: immediate return to reset values; no `done`.

## Timing
- Accept edge is cycle 0. `done` is high in cycle CHANNELS+2 without spread, or 2·CHANNELS+1 with spread.
- `done` lasts exactly one cycle. `data_out` changes only on the DONE cycle and holds until the next DONE.
- The earliest next accept is the cycle after DONE.
- The phase update is visible to the next sample.

## Configuration
- `TREMOLO_STEREO_SPREAD_EN` defined: channel c uses phase + c·2^PHASE_WIDTH/CHANNELS (integer division) and gets its own LFO state, for per-channel modulation.
- Undefined: one LFO evaluation per sample, shared by all channels; the FSM goes LFO→MUL×CHANNELS.

## Test plan
- Reset, no spread, CHANNELS=2, α=0, data_in ch0=1000, ch1=−2000 → data_out {1000, −2000}; `done` in cycle 4 only; `busy` cycles 0–4.
- 7 alpha presses, 1 wave press (square), phase 0, x=20000 → m=32766, y saturates to 32767. Same with x=−20000 → −32768.
- 3 alpha presses (16384), triangle, phase 0, x=1000 → w=−32768, m=−16384, y=500.
- PHASE_WIDTH=24, 7 rate presses (incr 6991), 2400 samples → phase = 1184 (wrap verified). A `cs && my_turn` pulse mid-sample is ignored. A key press mid-sample takes effect on the following sample.
- Spread build, CHANNELS=2, square, α=32767, phase 0, x=1000 on both → ch0=1999, ch1=0; `done` in cycle 5.
- `rst` asserted in MUL → next cycle IDLE, `data_out`=0, no `done`, options=0. A new sample afterwards is processed normally.
